cond_flag_unit: RTL and testbench

Conditional-execution and status-flag stage directly downstream of the ALU in the single-cycle 32-bit ARM-subset core. It holds the architectural N, Z, C, V flags and captures the ALU's `{N,Z,C,V}` check vector under controller-supplied flag-write enables. Each cycle it evaluates the current instruction's 4-bit condition field against the stored flags. Its `cond_ex` result gates the controller's PC-source, register-write and memory-write strobes before they reach the datapath.

---
 rtl/cond_flag_unit_if.sv | 24 ++
 rtl/cond_flag_unit.sv | 59 +++++
 tb/tb_cond_flag_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cond_flag_unit_if.sv
// Controller-side bundle for the condition/flag stage. No handshake: every field is valid every cycle.
interface cond_flag_unit_if;
  logic [3:0] cond;
  logic [3:0] alu_checks;
  logic [1:0] flag_w;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic       cond_ex;
  logic       pc_src_g;
  logic       reg_write_g;
  logic       mem_write_g;
  logic [3:0] flags;

  modport master (
    output cond, alu_checks, flag_w, pc_src, reg_write, mem_write,
    input  cond_ex, pc_src_g, reg_write_g, mem_write_g, flags
  );

  modport slave (
    input  cond, alu_checks, flag_w, pc_src, reg_write, mem_write,
    output cond_ex, pc_src_g, reg_write_g, mem_write_g, flags
  );
endinterface

// File: rtl/cond_flag_unit.sv
// NZCV flag store and condition evaluator; cond_ex and gated strobes are combinational,
// flag writes land one edge later. Accepts an instruction every cycle; no backpressure.
module cond_flag_unit (
  input  logic              clk,
  input  logic              rst_n,
  cond_flag_unit_if.slave   bus
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       n_f, z_f, c_f, v_f;
  logic       pass;
  logic       nz_we, cv_we;

  assign {n_f, z_f} = nz_q;
  assign {c_f, v_f} = cv_q;

  // Decode looks only at stored flags so an instruction never sees its own ALU result.
  always_comb begin
    pass = 1'b1;
    case (bus.cond)
      4'b0000: pass = z_f;
      4'b0001: pass = !z_f;
      4'b0010: pass = c_f;
      4'b0011: pass = !c_f;
      4'b0100: pass = n_f;
      4'b0101: pass = !n_f;
      4'b0110: pass = v_f;
      4'b0111: pass = !v_f;
      4'b1000: pass = c_f & !z_f;
      4'b1001: pass = !c_f | z_f;
      4'b1010: pass = (n_f == v_f);
      4'b1011: pass = (n_f != v_f);
      4'b1100: pass = !z_f & (n_f == v_f);
      4'b1101: pass = z_f | (n_f != v_f);
      default: pass = 1'b1;
    endcase
  end

  assign nz_we = bus.flag_w[1] & pass;
  assign cv_we = bus.flag_w[0] & pass;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      if (nz_we) nz_q <= bus.alu_checks[3:2];
      if (cv_we) cv_q <= bus.alu_checks[1:0];
    end
  end

  assign bus.cond_ex     = pass;
  assign bus.pc_src_g    = bus.pc_src & pass;
  assign bus.reg_write_g = bus.reg_write & pass;
  assign bus.mem_write_g = bus.mem_write & pass;
  assign bus.flags       = {nz_q, cv_q};

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed table, exhaustive decode sweep and randomized run against a model.
module tb_cond_flag_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cond_flag_unit_if bus ();

  cond_flag_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] fl;
    logic       exp;
  } vec_t;

  vec_t vecs [13];

  // Reference: conditions come in complementary pairs; bit 0 inverts the base test.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    bus.cond       = 4'b1110;
    bus.flag_w     = 2'b11;
    bus.alu_checks = f;
    step();
    bus.flag_w     = 2'b00;
    #1;
  endtask

  logic [3:0] model;
  logic       exp_pass;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.cond = 4'b1110;
    bus.alu_checks = 4'b1111;
    bus.flag_w = 2'b11;
    bus.pc_src = 1'b1;
    bus.reg_write = 1'b1;
    bus.mem_write = 1'b0;

    vecs[0]  = '{4'b1011, 4'b1000, 1'b1};
    vecs[1]  = '{4'b1010, 4'b1000, 1'b0};
    vecs[2]  = '{4'b1100, 4'b1000, 1'b0};
    vecs[3]  = '{4'b1101, 4'b1000, 1'b1};
    vecs[4]  = '{4'b1010, 4'b1001, 1'b1};
    vecs[5]  = '{4'b1100, 4'b1001, 1'b1};
    vecs[6]  = '{4'b1000, 4'b0110, 1'b0};
    vecs[7]  = '{4'b1001, 4'b0110, 1'b1};
    vecs[8]  = '{4'b0000, 4'b0100, 1'b1};
    vecs[9]  = '{4'b0010, 4'b0010, 1'b1};
    vecs[10] = '{4'b0011, 4'b0010, 1'b0};
    vecs[11] = '{4'b0111, 4'b0000, 1'b1};
    vecs[12] = '{4'b1111, 4'b0000, 1'b1};

    // Reset held two edges against a full flag-write request.
    step();
    step();
    check("reset_flags", bus.flags, 4'b0000);
    check("reset_pc_g", {3'b0, bus.pc_src_g}, 4'b0001);
    check("reset_mem_g", {3'b0, bus.mem_write_g}, 4'b0000);
    rst_n = 1'b1;
    bus.flag_w = 2'b00;
    bus.cond = 4'b0000;
    #1;
    check("post_reset_eq", {3'b0, bus.cond_ex}, 4'b0000);
    bus.cond = 4'b0001;
    #1;
    check("post_reset_ne", {3'b0, bus.cond_ex}, 4'b0001);

    // SUBS equal then conditional branch.
    bus.pc_src = 1'b0;
    bus.cond = 4'b1110;
    bus.flag_w = 2'b11;
    bus.alu_checks = 4'b0110;
    step();
    check("subs_flags", bus.flags, 4'b0110);
    bus.flag_w = 2'b00;
    bus.cond = 4'b0000;
    bus.pc_src = 1'b1;
    #1;
    check("beq_taken", {3'b0, bus.pc_src_g}, 4'b0001);
    bus.cond = 4'b0001;
    #1;
    check("bne_not_taken", {3'b0, bus.pc_src_g}, 4'b0000);
    bus.pc_src = 1'b0;

    // NZ and CV groups written independently.
    load_flags(4'b0011);
    bus.flag_w = 2'b10;
    bus.alu_checks = 4'b1000;
    step();
    check("nz_only", bus.flags, 4'b1011);
    bus.flag_w = 2'b01;
    bus.alu_checks = 4'b0100;
    step();
    check("cv_only", bus.flags, 4'b1000);

    // Failed condition blocks strobes and flag writes.
    load_flags(4'b0000);
    bus.cond = 4'b0000;
    bus.flag_w = 2'b11;
    bus.alu_checks = 4'b1111;
    bus.reg_write = 1'b1;
    bus.mem_write = 1'b1;
    #1;
    check("fail_reg_g", {3'b0, bus.reg_write_g}, 4'b0000);
    check("fail_mem_g", {3'b0, bus.mem_write_g}, 4'b0000);
    step();
    check("fail_flags_hold", bus.flags, 4'b0000);
    bus.flag_w = 2'b00;

    // Same-cycle ALU result must not influence its own condition.
    load_flags(4'b0000);
    bus.cond = 4'b0000;
    bus.alu_checks = 4'b0100;
    #1;
    check("no_alu_path", {3'b0, bus.cond_ex}, 4'b0000);

    for (int i = 0; i < 13; i++) begin
      load_flags(vecs[i].fl);
      bus.cond = vecs[i].cond;
      #1;
      check($sformatf("vec%0d_cond%b_fl%b", i, vecs[i].cond, vecs[i].fl),
            {3'b0, bus.cond_ex}, {3'b0, vecs[i].exp});
    end

    // Mid-program reset clears, then capture resumes.
    load_flags(4'b1101);
    rst_n = 1'b0;
    bus.flag_w = 2'b11;
    bus.cond = 4'b1110;
    bus.alu_checks = 4'b1010;
    step();
    check("mid_reset", bus.flags, 4'b0000);
    rst_n = 1'b1;
    step();
    check("resume_capture", bus.flags, 4'b1010);
    bus.flag_w = 2'b00;

    for (int f = 0; f < 16; f++) begin
      load_flags(f[3:0]);
      check($sformatf("sweep_load_%0d", f), bus.flags, f[3:0]);
      for (int c = 0; c < 16; c++) begin
        bus.cond = c[3:0];
        #1;
        check($sformatf("sweep_c%b_f%b", c[3:0], f[3:0]),
              {3'b0, bus.cond_ex}, {3'b0, ref_pass(c[3:0], f[3:0])});
      end
    end

    // Randomized program with occasional resets.
    rst_n = 1'b0;
    step();
    model = 4'b0000;
    for (int k = 0; k < 1500; k++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      bus.cond = 4'($urandom_range(0, 15));
      bus.alu_checks = 4'($urandom_range(0, 15));
      bus.flag_w = 2'($urandom_range(0, 3));
      bus.pc_src = 1'($urandom_range(0, 1));
      bus.reg_write = 1'($urandom_range(0, 1));
      bus.mem_write = 1'($urandom_range(0, 1));
      #1;
      exp_pass = ref_pass(bus.cond, model);
      check("rand_cond_ex", {3'b0, bus.cond_ex}, {3'b0, exp_pass});
      check("rand_gated", {1'b0, bus.pc_src_g, bus.reg_write_g, bus.mem_write_g},
            {1'b0, bus.pc_src & exp_pass, bus.reg_write & exp_pass, bus.mem_write & exp_pass});
      if (!rst_n) model = 4'b0000;
      else if (exp_pass) begin
        if (bus.flag_w[1]) model[3:2] = bus.alu_checks[3:2];
        if (bus.flag_w[0]) model[1:0] = bus.alu_checks[1:0];
      end
      step();
      check("rand_flags", bus.flags, model);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
